// File: rtl/ad5328_pkg.sv
// Shared definitions for the AD5328 channel scheduler: word prefixes, sizes,
// FSM state encoding and the data-word builder.
package ad5328_pkg;

   localparam int unsigned N_CH   = 8;
   localparam int unsigned CODE_W = 12;
   localparam int unsigned N_INIT = 10;

   localparam logic       DATA      = 1'b0;
   localparam logic [2:0] CTRL_GAIN = 3'b100;
   localparam logic [2:0] CTRL_LDAC = 3'b101;

   typedef enum logic [2:0] {
      DELAY,
      INIT,
      IDLE,
      ISSUE,
      WAIT_LO,
      WAIT_HI
   } state_t;

   function automatic logic [15:0] mk_data_word(input logic [2:0] ch,
                                                input logic [CODE_W-1:0] code);
      return {DATA, ch, code};
   endfunction

endpackage

// File: rtl/ad5328_ch_sched_if.sv
// Write handshake between the channel scheduler and the AD5328 serial core.
interface ad5328_ch_sched_if;

   logic        wr_req;
   logic [15:0] wr_data;
   logic        ready;

   modport master (output wr_req, output wr_data, input ready);
   modport slave  (input wr_req, input wr_data, output ready);

endinterface

// File: rtl/ad5328_rr_arb.sv
// Combinational 8-way round-robin finder: first set request after ptr, wrapping.
module ad5328_rr_arb
   import ad5328_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  logic [2:0]      ptr,
   output logic [2:0]      gnt_idx,
   output logic            gnt_vld
);

   logic [2:0] cand;

   // i = 8 wraps cand back to ptr itself, so the last-served channel has lowest priority
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = ptr;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         cand = ptr + 3'(i);
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/ad5328_ch_sched.sv
// AD5328 power-up sequencer and round-robin per-channel write scheduler
// feeding the serial core through a req/ready handshake.
module ad5328_ch_sched
   import ad5328_pkg::*;
#(
   parameter int unsigned       INIT_DELAY   = 100,
   parameter logic [3:0]        GAIN_BUF_CFG = 4'b0000,
   parameter logic [CODE_W-1:0] DEFAULT_CODE = 12'h000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        ch_set,
   input  logic [N_CH*CODE_W-1:0] ch_value,
   output logic [N_CH-1:0]        ch_pend,
   output logic                   init_done,
   ad5328_ch_sched_if.master      wr_if
);

   localparam int unsigned DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;

   state_t            state;
   logic [DW-1:0]     dly_cnt;
   logic [3:0]        init_idx;
   logic [2:0]        rr_ptr;
   logic [15:0]       wr_data_q;
   logic [CODE_W-1:0] shadow [N_CH];

   logic [2:0]        gnt_idx;
   logic              gnt_vld;
   logic [N_CH-1:0]   gnt_clr;
   logic [15:0]       init_word;

   ad5328_rr_arb u_arb (
      .req     (ch_pend),
      .ptr     (rr_ptr),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      gnt_clr = '0;
      if (state == IDLE && gnt_vld)
         gnt_clr = N_CH'(1) << gnt_idx;
   end

   always_comb begin
      if (init_idx == 4'd0)
         init_word = {CTRL_GAIN, 9'b0, GAIN_BUF_CFG};
      else if (init_idx == 4'd1)
         init_word = {CTRL_LDAC, 13'b0};
      else
         init_word = mk_data_word(3'(init_idx - 4'd2), DEFAULT_CODE);
   end

   // Strobe only while the core is ready, so the request is never lost
   assign wr_if.wr_req  = (state == ISSUE) && wr_if.ready;
   assign wr_if.wr_data = wr_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DELAY;
         dly_cnt   <= '0;
         init_idx  <= '0;
         init_done <= 1'b0;
         rr_ptr    <= 3'd7;
         wr_data_q <= '0;
         ch_pend   <= '0;
         for (int unsigned i = 0; i < N_CH; i++)
            shadow[i] <= DEFAULT_CODE;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++)
            if (ch_set[i])
               shadow[i] <= ch_value[CODE_W*i +: CODE_W];
         // A new strobe on the channel being granted keeps it pending
         ch_pend <= (ch_pend & ~gnt_clr) | ch_set;

         case (state)
            DELAY: begin
               if (dly_cnt == DW'(INIT_DELAY - 1))
                  state <= INIT;
               else
                  dly_cnt <= dly_cnt + 1'b1;
            end
            INIT: begin
               wr_data_q <= init_word;
               state     <= ISSUE;
            end
            IDLE: begin
               if (gnt_vld) begin
                  wr_data_q <= mk_data_word(gnt_idx, shadow[gnt_idx]);
                  rr_ptr    <= gnt_idx;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (wr_if.ready)
                  state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!wr_if.ready)
                  state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (wr_if.ready) begin
                  if (init_done) begin
                     state <= IDLE;
                  end else if (init_idx == 4'(N_INIT - 1)) begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     init_idx <= init_idx + 1'b1;
                     state    <= INIT;
                  end
               end
            end
            default: state <= DELAY;
         endcase
      end
   end

endmodule

// File: tb/tb_ad5328_ch_sched.sv
// Bench for ad5328_ch_sched: core model with a 34-cycle busy window per write,
// vector table for multi-channel round-robin plus directed corner sequences.
module tb_ad5328_ch_sched;
   import ad5328_pkg::*;

   localparam int unsigned INIT_DELAY = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ch_set = '0;
   logic [95:0] ch_value = '0;
   logic [7:0]  ch_pend;
   logic        init_done;

   ad5328_ch_sched_if bus ();

   ad5328_ch_sched #(
      .INIT_DELAY   (INIT_DELAY),
      .GAIN_BUF_CFG (4'b0000),
      .DEFAULT_CODE (12'h000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch_set    (ch_set),
      .ch_value  (ch_value),
      .ch_pend   (ch_pend),
      .init_done (init_done),
      .wr_if     (bus.master)
   );

   always #5 clk = ~clk;

   // Core model: ready drops for 34 cycles after each accepted request
   int unsigned busy;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          busy <= 0;
      else if (bus.wr_req) busy <= 34;
      else if (busy != 0)  busy <= busy - 1;
   end
   assign bus.ready = (busy == 0);

   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int checks = 0;
   int errors = 0;
   logic [15:0] wq[$];
   int          wc[$];
   logic        prev_req = 1'b0;

   always @(negedge clk) begin
      if (rst_n && bus.wr_req) begin
         wq.push_back(bus.wr_data);
         wc.push_back(cyc);
         checks++;
         if (prev_req || !bus.ready) begin
            errors++;
            $display("FAIL req_pulse: prev_req=%0b ready=%0b at cyc %0d, required single pulse while ready",
                     prev_req, bus.ready, cyc);
         end
      end
      prev_req = rst_n && bus.wr_req;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_w(input int j);
      if (wq.size() > j) return {16'h0, wq[j]};
      return 32'hDEAD_BEEF;
   endfunction

   task automatic wait_writes(input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (wq.size() >= n) break;
         @(posedge clk);
      end
      #1;
      chk("writes_seen", 32'(wq.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         @(posedge clk);
         #1;
         if (bus.ready && ch_pend == 8'h00) break;
      end
      chk("idle_reached", 32'(c < budget), 32'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] m, input logic [95:0] v);
      @(negedge clk);
      ch_set   = m;
      ch_value = v;
      @(negedge clk);
      ch_set = '0;
   endtask

   function automatic logic [95:0] one_code(input int ch, input logic [11:0] c);
      logic [7:0][11:0] t;
      t = {8{12'hEEE}};
      t[ch] = c;
      return t;
   endfunction

   task automatic run_init();
      logic [15:0] e;
      wq.delete();
      wc.delete();
      @(negedge clk);
      rst_n = 1'b1;
      wait_writes(10, INIT_DELAY + 10 * 60);
      chk("init_done_early", 32'(init_done), 32'd0);
      for (int i = 0; i < 10; i++) begin
         e = (i == 0) ? 16'h8000 : (i == 1) ? 16'hA000 : {1'b0, 3'(i - 2), 12'h000};
         chk($sformatf("init_word%0d", i), get_w(i), {16'h0, e});
      end
      if (wc.size() > 0)
         chk("first_req_cycle", 32'(wc[0] >= int'(INIT_DELAY) && wc[0] <= int'(INIT_DELAY) + 2), 32'd1);
      wait_idle(80);
      chk("init_done_set", 32'(init_done), 32'd1);
      chk("init_count", 32'(wq.size()), 32'd10);
   endtask

   typedef struct {
      logic [7:0]       set;
      logic [7:0][11:0] code;
      int               n;
      logic [7:0][15:0] exp;
   } vec_t;

   vec_t vt[4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0].set = 8'hFF;
      vt[0].n   = 8;
      for (int i = 0; i < 8; i++) begin
         vt[0].code[i] = 12'(i * 257);
         vt[0].exp[i]  = {1'b0, 3'(i), 12'(i * 257)};
      end
      vt[1].set = 8'h44; vt[1].code = {8{12'hEEE}};
      vt[1].code[2] = 12'h0AA; vt[1].code[6] = 12'hF0F;
      vt[1].n = 2; vt[1].exp = '0; vt[1].exp[0] = 16'h20AA; vt[1].exp[1] = 16'h6F0F;
      vt[2].set = 8'h81; vt[2].code = {8{12'hEEE}};
      vt[2].code[0] = 12'h123; vt[2].code[7] = 12'hFFF;
      vt[2].n = 2; vt[2].exp = '0; vt[2].exp[0] = 16'h7FFF; vt[2].exp[1] = 16'h0123;
      vt[3].set = 8'h03; vt[3].code = {8{12'hEEE}};
      vt[3].code[0] = 12'h001; vt[3].code[1] = 12'h800;
      vt[3].n = 2; vt[3].exp = '0; vt[3].exp[0] = 16'h1800; vt[3].exp[1] = 16'h0001;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ch_pend", 32'(ch_pend), 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      chk("rst_wr_req", 32'(bus.wr_req), 32'h0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'h0);

      run_init();

      // Vector table: strobe, collect writes, compare order and words
      for (int k = 0; k < 4; k++) begin
         wq.delete();
         wc.delete();
         strobe(vt[k].set, vt[k].code);
         wait_writes(vt[k].n, vt[k].n * 60);
         wait_idle(80);
         chk($sformatf("vec%0d_count", k), 32'(wq.size()), 32'(vt[k].n));
         for (int j = 0; j < vt[k].n; j++)
            chk($sformatf("vec%0d_word%0d", k, j), get_w(j), {16'h0, vt[k].exp[j]});
      end

      // Latency: strobe cycle N -> wr_req in cycle N+2, single pulse
      wq.delete();
      strobe(8'h08, one_code(3, 12'hABC));
      chk("lat_pend_set", 32'(ch_pend), 32'h08);
      chk("lat_req_early", 32'(bus.wr_req), 32'h0);
      @(negedge clk);
      chk("lat_req", 32'(bus.wr_req), 32'h1);
      chk("lat_data", 32'(bus.wr_data), 32'h3ABC);
      chk("lat_pend_clr", 32'(ch_pend), 32'h00);
      @(negedge clk);
      chk("lat_pulse", 32'(bus.wr_req), 32'h0);
      chk("lat_data_hold", 32'(bus.wr_data), 32'h3ABC);
      wait_idle(80);
      chk("lat_count", 32'(wq.size()), 32'd1);

      // Grant of ch5 coincides with a fresh strobe on ch5
      wq.delete();
      @(negedge clk);
      ch_set = 8'h20; ch_value = one_code(5, 12'h5A5);
      @(negedge clk);
      ch_set = 8'h20; ch_value = one_code(5, 12'h5B6);
      @(negedge clk);
      ch_set = '0;
      chk("coin_req", 32'(bus.wr_req), 32'h1);
      chk("coin_data", 32'(bus.wr_data), 32'h55A5);
      chk("coin_pend", 32'(ch_pend), 32'h20);
      wait_writes(2, 120);
      wait_idle(80);
      chk("coin_count", 32'(wq.size()), 32'd2);
      chk("coin_word0", get_w(0), 32'h55A5);
      chk("coin_word1", get_w(1), 32'h55B6);

      // Two strobes on ch2 while the core is busy coalesce into one write
      wq.delete();
      strobe(8'h01, one_code(0, 12'h555));
      wait_writes(1, 20);
      strobe(8'h04, one_code(2, 12'h111));
      repeat (4) @(negedge clk);
      strobe(8'h04, one_code(2, 12'h222));
      chk("coal_pend", 32'(ch_pend), 32'h04);
      chk("coal_busy", 32'(bus.ready), 32'h0);
      wait_writes(2, 120);
      wait_idle(80);
      chk("coal_count", 32'(wq.size()), 32'd2);
      chk("coal_word0", get_w(0), 32'h0555);
      chk("coal_word1", get_w(1), 32'h2222);

      // Reset in WAIT_HI with a channel still pending; init must replay
      wq.delete();
      strobe(8'h12, {12'hEEE, 12'hEEE, 12'hEEE, 12'h444, 12'hEEE, 12'hEEE, 12'h321, 12'hEEE});
      wait_writes(1, 20);
      chk("rr_first", get_w(0), 32'h4444);
      chk("rr_pend_left", 32'(ch_pend), 32'h02);
      repeat (10) @(negedge clk);
      chk("mid_busy", 32'(bus.ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_wr_req", 32'(bus.wr_req), 32'h0);
      chk("arst_ch_pend", 32'(ch_pend), 32'h0);
      chk("arst_init_done", 32'(init_done), 32'h0);
      chk("arst_wr_data", 32'(bus.wr_data), 32'h0);
      repeat (3) @(negedge clk);
      run_init();
      chk("post_rst_pend", 32'(ch_pend), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
